// File: rtl/hex_entry_pkg.sv
// Shared constants, button indices and action decode for the hex_entry block.
package hex_entry_pkg;
  localparam int NUM_DIGITS = 8;
  localparam int CURSOR_W   = 3;
  localparam int NIB_W      = 4;
  localparam int DATA_W     = NUM_DIGITS * NIB_W;
  localparam int NUM_BTNS   = 5;

  // Lower index wins when several presses land in the same cycle.
  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_D = 2;
  localparam int BTN_L = 3;
  localparam int BTN_R = 4;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_COMMIT,
    ACT_INC,
    ACT_DEC,
    ACT_LEFT,
    ACT_RIGHT
  } action_e;

  typedef struct packed {
    logic [NUM_DIGITS-1:0][NIB_W-1:0] nib;
    logic [CURSOR_W-1:0]              cursor;
  } entry_t;

  function automatic action_e pick_action(logic [NUM_BTNS-1:0] press);
    action_e act;
    act = ACT_NONE;
    if      (press[BTN_C]) act = ACT_COMMIT;
    else if (press[BTN_U]) act = ACT_INC;
    else if (press[BTN_D]) act = ACT_DEC;
    else if (press[BTN_L]) act = ACT_LEFT;
    else if (press[BTN_R]) act = ACT_RIGHT;
    return act;
  endfunction
endpackage

// File: rtl/hex_entry_if.sv
// Button inputs and edited-word outputs of hex_entry.
interface hex_entry_if;
  import hex_entry_pkg::*;
  logic                BTNU, BTND, BTNL, BTNR, BTNC;
  logic [DATA_W-1:0]   data;
  logic [CURSOR_W-1:0] cursor;
  logic                valid;

  modport master (output BTNU, BTND, BTNL, BTNR, BTNC, input data, cursor, valid);
  modport slave  (input BTNU, BTND, BTNL, BTNR, BTNC, output data, cursor, valid);
endinterface

// File: rtl/debounce.sv
// One button lane: 2-FF synchronizer, stable-window debounce and rising-edge press pulse.
module debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic CLK100MHZ,
  input  logic CPU_RESETN,
  input  logic din,
  output logic stable,
  output logic press
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt;
  logic             stable_q;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sync_q   <= '0;
      cnt      <= '0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      press    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], din};
      // Any return to the stable level restarts the window, so short glitches vanish.
      if (sync_q[1] == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      stable_q <= stable;
      press    <= stable & ~stable_q;
    end
  end
endmodule

// File: rtl/hex_entry.sv
// Five debounced buttons drive a nibble cursor and a 32-bit word; centre commits.
module hex_entry import hex_entry_pkg::*; #(
  parameter int                CLK_FREQUENCY   = 100_000_000,
  parameter int                DEBOUNCE_MS     = 10,
  parameter int                DEBOUNCE_CYCLES = CLK_FREQUENCY / 1000 * DEBOUNCE_MS,
  parameter logic [DATA_W-1:0] INIT_DATA       = 32'h0000_0000
) (
  input  logic      CLK100MHZ,
  input  logic      CPU_RESETN,
  hex_entry_if.slave bus
);
  logic [NUM_BTNS-1:0] btn_raw, press, stable_unused;

  always_comb begin
    btn_raw        = '0;
    btn_raw[BTN_C] = bus.BTNC;
    btn_raw[BTN_U] = bus.BTNU;
    btn_raw[BTN_D] = bus.BTND;
    btn_raw[BTN_L] = bus.BTNL;
    btn_raw[BTN_R] = bus.BTNR;
  end

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [NUM_BTNS-1:0] (
    .CLK100MHZ (CLK100MHZ),
    .CPU_RESETN(CPU_RESETN),
    .din       (btn_raw),
    .stable    (stable_unused),
    .press     (press)
  );

  entry_t  st_q, st_d;
  logic    valid_q, valid_d;
  action_e act;

  always_comb begin
    act     = pick_action(press);
    st_d    = st_q;
    valid_d = 1'b0;
    case (act)
      ACT_COMMIT: valid_d = 1'b1;
      ACT_INC:    st_d.nib[st_q.cursor] = st_q.nib[st_q.cursor] + NIB_W'(1);
      ACT_DEC:    st_d.nib[st_q.cursor] = st_q.nib[st_q.cursor] - NIB_W'(1);
      ACT_LEFT:   st_d.cursor = st_q.cursor + CURSOR_W'(1);
      ACT_RIGHT:  st_d.cursor = st_q.cursor - CURSOR_W'(1);
      default:    ;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      st_q.nib    <= INIT_DATA;
      st_q.cursor <= '0;
      valid_q     <= 1'b0;
    end else begin
      st_q    <= st_d;
      valid_q <= valid_d;
    end
  end

  assign bus.data   = st_q.nib;
  assign bus.cursor = st_q.cursor;
  assign bus.valid  = valid_q;
endmodule

// File: tb/tb_hex_entry.sv
// Directed plus randomized button sequences checked against a nibble/cursor reference model.
module tb_hex_entry;
  import hex_entry_pkg::*;

  localparam int          N    = 4;
  localparam logic [31:0] INIT = 32'h1234_5678;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hex_entry_if bus();

  hex_entry #(.DEBOUNCE_CYCLES(N), .INIT_DATA(INIT)) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rst_n),
    .bus       (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int m_nib[8];
  int m_cur;
  int m_valid_cnt = 0;
  int valid_seen  = 0;

  always @(negedge clk) if (bus.valid === 1'b1) valid_seen++;

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_word();
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) w[4*i +: 4] = 4'(m_nib[i]);
    return w;
  endfunction

  // mask bits: [4]=C [3]=U [2]=D [1]=L [0]=R
  task automatic set_btns(input logic [4:0] m);
    bus.BTNC = m[4]; bus.BTNU = m[3]; bus.BTND = m[2]; bus.BTNL = m[1]; bus.BTNR = m[0];
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_nib[i] = int'(INIT[4*i +: 4]);
    m_cur = 0;
  endtask

  task automatic model_apply(input logic [4:0] m);
    if      (m[4]) m_valid_cnt++;
    else if (m[3]) m_nib[m_cur] = (m_nib[m_cur] + 1) % 16;
    else if (m[2]) m_nib[m_cur] = (m_nib[m_cur] + 15) % 16;
    else if (m[1]) m_cur = (m_cur + 1) % 8;
    else if (m[0]) m_cur = (m_cur + 7) % 8;
  endtask

  task automatic do_reset();
    set_btns(5'b0);
    rst_n = 1'b0;
    tick(2);
    model_reset();
    chk("rst_data", bus.data, INIT);
    chk("rst_cursor", 32'(bus.cursor), 32'd0);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    rst_n = 1'b1;
    tick(2);
  endtask

  // Rise at cycle 0, action visible at cycle N+4, hold >= N+5 cycles.
  task automatic press_op(input string tag, input logic [4:0] m, input int hold, input int gap);
    logic [31:0] old_d;
    int          old_c;
    old_d = m_word();
    old_c = m_cur;
    set_btns(m);
    tick(N + 3);
    chk({tag, ":pre_data"}, bus.data, old_d);
    chk({tag, ":pre_cursor"}, 32'(bus.cursor), 32'(old_c));
    chk({tag, ":pre_valid"}, 32'(bus.valid), 32'd0);
    tick(1);
    model_apply(m);
    chk({tag, ":data"}, bus.data, m_word());
    chk({tag, ":cursor"}, 32'(bus.cursor), 32'(m_cur));
    chk({tag, ":valid"}, 32'(bus.valid), 32'(m[4]));
    tick(1);
    chk({tag, ":valid_off"}, 32'(bus.valid), 32'd0);
    tick(hold - (N + 5));
    set_btns(5'b0);
    tick(gap);
    chk({tag, ":end_data"}, bus.data, m_word());
    chk({tag, ":end_cursor"}, 32'(bus.cursor), 32'(m_cur));
    chk({tag, ":valid_cnt"}, 32'(valid_seen), 32'(m_valid_cnt));
  endtask

  task automatic glitch_op(input string tag, input logic [4:0] m, input int len, input int gap);
    set_btns(m);
    tick(len);
    set_btns(5'b0);
    tick(gap);
    chk({tag, ":data"}, bus.data, m_word());
    chk({tag, ":cursor"}, 32'(bus.cursor), 32'(m_cur));
    chk({tag, ":valid_cnt"}, 32'(valid_seen), 32'(m_valid_cnt));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] m;
    int         r;
    set_btns(5'b0);
    model_reset();
    tick(2);
    do_reset();

    // First press: exact latency, single increment.
    press_op("first_u", 5'b01000, 10, N + 6);
    chk("first_u_word", bus.data, 32'h1234_5679);

    // Cursor wrap both ways.
    do_reset();
    press_op("wrap_r", 5'b00001, 10, N + 4);
    chk("wrap_r_cursor", 32'(bus.cursor), 32'd7);
    press_op("wrap_u", 5'b01000, 10, N + 4);
    chk("wrap_u_word", bus.data, 32'h2234_5678);
    press_op("wrap_l", 5'b00010, 10, N + 4);
    chk("wrap_l_cursor", 32'(bus.cursor), 32'd0);

    // Nibble wrap without borrow.
    do_reset();
    for (int i = 0; i < 8; i++) press_op("dec", 5'b00100, 10, N + 4);
    chk("dec_zero_word", bus.data, 32'h1234_5670);
    press_op("dec_wrap", 5'b00100, 10, N + 4);
    chk("dec_wrap_word", bus.data, 32'h1234_567F);

    // Glitches shorter than the window.
    do_reset();
    for (int g = 1; g < N; g++) glitch_op("glitch", 5'b01000, g, 6);
    chk("glitch_word", bus.data, INIT);

    // C and U together: commit wins.
    do_reset();
    press_op("c_and_u", 5'b11000, 10, N + 6);
    chk("c_and_u_word", bus.data, INIT);

    // Reset while BTNL is being debounced.
    do_reset();
    set_btns(5'b00010);
    tick(3);
    rst_n = 1'b0;
    tick(2);
    chk("midrst_cursor_low", 32'(bus.cursor), 32'd0);
    rst_n = 1'b1;
    model_reset();
    tick(N + 3);
    chk("midrst_cursor_pre", 32'(bus.cursor), 32'd0);
    tick(1);
    model_apply(5'b00010);
    chk("midrst_cursor_post", 32'(bus.cursor), 32'(m_cur));
    set_btns(5'b0);
    tick(N + 6);
    chk("midrst_cursor_end", 32'(bus.cursor), 32'd1);

    // Randomized sequences.
    do_reset();
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        m = 5'($urandom_range(1, 31));
        glitch_op("rnd_glitch", m, $urandom_range(1, N - 1), $urandom_range(2, 6));
      end else begin
        if (r < 7) m = 5'(1 << $urandom_range(0, 4));
        else       m = 5'($urandom_range(1, 31));
        press_op("rnd_press", m, $urandom_range(10, 14), $urandom_range(N + 4, N + 10));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
